exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU; sits directly upstream of the ALU.
//  Owns PC, 4x8 register file, Z flag and instruction register.
//  Fetches over a req/valid handshake, drives ALU operands/op/imm, and writes back ALU result and zero_flag.
// PARAMETERS
//  RESET_PC       8'h00  PC value loaded on reset
//  FETCH_TIMEOUT  15     max FETCH cycles with imem_valid low before fault; 0 = no timeout
// PORTS
//  clk           in   1  single clock; all state updates on rising edge
//  rst           in   1  synchronous, active-high reset
//  imem_req      out  1  fetch request; high for every cycle in FETCH
//  imem_addr     out  8  fetch address (= pc)
//  imem_valid    in   1  instruction returned this cycle; sampled only in FETCH
//  imem_data     in   8  instruction byte; captured when imem_valid=1 in FETCH
//  alu_src1      out  8  ALU operand 1 (regs[rd])
//  alu_src2      out  8  ALU operand 2 (regs[rt])
//  alu_imm2      out  2  ALU immediate (ir[1:0])
//  alu_imm_sel   out  1  1 = ALU uses alu_imm2
//  alu_op        out  2  00 ADD, 01 SUB, 10 NAND
//  alu_result    in   8  ALU result (combinational from outputs above)
//  alu_zero      in   1  ALU zero flag
//  pc            out  8  current PC
//  retire        out  1  one-cycle pulse in WRITEBACK
//  halted        out  1  core stopped (HALT opcode or fault)
//  fault         out  1  fetch-timeout fault
//  dbg_sel       in   2  debug register index
//  dbg_data      out  8  regs[dbg_sel], combinational
// BEHAVIOUR
//  Encoding: ir[7:4] opcode, ir[3:2] rd, ir[1:0] rt or imm2. Ops rd = rd OP x:
//   0000 ADD, 0001 SUB, 0010 NAND (x=regs[rt])
//   0100 ADDI, 0101 SUBI, 0110 NANDI (x=zext imm2)
//   1000 BZ: if Z, pc = pc + sext(ir[3:0]); else pc+1
//   1111 HALT; all other opcodes = NOP (pc+1)
//  Reset: regs, ir, Z, counter = 0; pc = RESET_PC; state = FETCH.
//   retire/halted/fault = 0; ALU outputs at idle values.
//  FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH. HALT is terminal until rst.
//  FETCH:
//   - imem_req=1, imem_addr=pc.
//   - On imem_valid=1: ir <= imem_data, go DECODE; imem_req drops next cycle.
//   - Else counter++. If FETCH_TIMEOUT!=0 and counter reaches FETCH_TIMEOUT: go HALT, fault=1, halted=1.
//   - Counter clears on leaving FETCH.
//  DECODE (1 cycle): latch op1=regs[rd], op2=regs[rt]. No read/write hazard: operands are latched before writeback.
//  EXECUTE (1 cycle): drive ALU from latched operands/ir; capture alu_result and alu_zero into holding regs.
//   - ALU opcodes only; other opcodes keep idle ALU values.
//  WRITEBACK (1 cycle): retire=1.
//   - ALU ops: regs[rd] <= result, Z <= zero, pc <= pc+1.
//   - BZ/NOP: pc update as above; Z unchanged.
//   - HALT: pc unchanged, go HALT, halted=1.
//  Idle ALU values outside EXECUTE: src1=src2=0, imm2=0, imm_sel=0, op=ADD.
//  Latency: 4 cycles/instruction when imem_valid is high in the first FETCH cycle; +1 per stall cycle.
//  PC arithmetic is 8-bit modulo 256; BZ offset 0 loops on itself (legal).
//  HALT state: imem_req=0, no register/PC/Z changes, imem_valid ignored.
//  Reset mid-operation: any state returns to reset values next cycle; partial fetch/writeback is discarded.
//   imem shares rst, so no stale responses arrive.
//  dbg_data shows a written value from the cycle after WRITEBACK.
// TESTING
//  1. Reset, imem returns 0x41 (ADDI r0,1) in first FETCH cycle:
//     -> retire in cycle 4, r0=1, Z=0, pc=1.
//  2. Sequence 0x47 (ADDI r1,3), 0x15 (SUB r1,r1), 0x8E (BZ -2):
//     -> r1=0, Z=1, pc after BZ = 2-2 = 0.
//  3. r0=0xFF, 0x20 (NAND r0,r0):
//     -> r0=0x00, Z=1; then 0x60 (NANDI r0,0) -> r0=0xFF, Z=0.
//  4. FETCH_TIMEOUT=4, imem_valid held low:
//     -> fault=1, halted=1 after 4 FETCH cycles; imem_req=0 thereafter.
//  5. 0xF0 (HALT):
//     -> halted=1, pc frozen, imem_req=0 for 20 cycles.
//     -> rst pulse restarts fetch at RESET_PC with halted=0.
//  6. RESET_PC=8'hFF, 0x30 (NOP): pc wraps to 0x00, retire pulses.
//     Stall imem_valid 3 cycles: instruction takes 7 cycles.

Source files
------------

// File: rtl/exec_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_sequencer_if : instruction-fetch handshake and ALU bus       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface exec_sequencer_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic [7:0] alu_src1;
  logic [7:0] alu_src2;
  logic [1:0] alu_imm2;
  logic       alu_imm_sel;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;

  modport master (
    output imem_req, imem_addr, alu_src1, alu_src2, alu_imm2, alu_imm_sel, alu_op,
    input  imem_valid, imem_data, alu_result, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, alu_src1, alu_src2, alu_imm2, alu_imm_sel, alu_op,
    output imem_valid, imem_data, alu_result, alu_zero
  );
endinterface
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_sequencer : fetch/decode/execute/writeback control for the   |
// | 8-bit CPU (PC, 4x8 register file, Z flag, instruction register)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module exec_sequencer #(
  parameter logic [7:0]  RESET_PC      = 8'h00,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  wire logic        clk,
  input  wire logic        rst,
  exec_sequencer_if.master bus,
  output logic [7:0]       pc,
  output logic             retire,
  output logic             halted,
  output logic             fault,
  input  wire logic [1:0]  dbg_sel,
  output logic [7:0]       dbg_data
);

  localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              z_q, z_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0][7:0]   regs_q, regs_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
  logic [7:0]        res_q, res_d;
  logic              rzero_q, rzero_d;
  logic              fault_q, fault_d;

  logic [3:0] opc;
  logic       is_alu, is_bz, is_halt, alu_active;

  assign opc     = ir_q[7:4];
  // ALU opcodes are 0000-0010 (register) and 0100-0110 (immediate)
  assign is_alu  = (opc[3] == 1'b0) && (opc[1:0] != 2'b11);
  assign is_bz   = (opc == 4'b1000);
  assign is_halt = (opc == 4'b1111);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    rzero_d = rzero_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.imem_data;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if ((FETCH_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          cnt_d   = '0;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        op1_d   = regs_q[ir_q[3:2]];
        op2_d   = regs_q[ir_q[1:0]];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_alu) begin
          res_d   = bus.alu_result;
          rzero_d = bus.alu_zero;
        end
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else begin
          pc_d = pc_q + 8'd1;
          if (is_alu) begin
            regs_d[ir_q[3:2]] = res_q;
            z_d               = rzero_q;
          end
          if (is_bz && z_q) begin
            pc_d = pc_q + {{4{ir_q[3]}}, ir_q[3:0]};
          end
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
      regs_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      rzero_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      rzero_q <= rzero_d;
      fault_q <= fault_d;
    end
  end

  // ALU sees latched operands only during EXECUTE of an ALU opcode; idle otherwise
  assign alu_active      = (state_q == S_EXECUTE) && is_alu;
  assign bus.alu_src1    = alu_active ? op1_q : 8'h00;
  assign bus.alu_src2    = alu_active ? op2_q : 8'h00;
  assign bus.alu_imm2    = alu_active ? ir_q[1:0] : 2'b00;
  assign bus.alu_imm_sel = alu_active & ir_q[6];
  assign bus.alu_op      = alu_active ? ir_q[5:4] : 2'b00;

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign pc            = pc_q;
  assign retire        = (state_q == S_WRITEBACK);
  assign halted        = (state_q == S_HALT);
  assign fault         = fault_q;
  assign dbg_data      = regs_q[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_exec_sequencer : directed vectors with a retire scoreboard     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_exec_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // ---------------- DUT A: RESET_PC=0, FETCH_TIMEOUT=4 ----------------
  exec_sequencer_if bus_a ();
  logic       rst_a = 1'b1;
  logic       en_a  = 1'b1;
  logic [7:0] prog_a [256];
  logic [1:0] dbg_sel_a = 2'd0;
  logic [7:0] pc_a, dbg_data_a;
  logic       retire_a, halted_a, fault_a;

  exec_sequencer #(.RESET_PC(8'h00), .FETCH_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .pc(pc_a), .retire(retire_a),
    .halted(halted_a), .fault(fault_a), .dbg_sel(dbg_sel_a), .dbg_data(dbg_data_a)
  );

  // ---------------- DUT B: RESET_PC=FF, FETCH_TIMEOUT=15 --------------
  exec_sequencer_if bus_b ();
  logic       rst_b = 1'b1;
  logic       en_b  = 1'b1;
  logic [7:0] prog_b [256];
  logic [1:0] dbg_sel_b = 2'd0;
  logic [7:0] pc_b, dbg_data_b;
  logic       retire_b, halted_b, fault_b;

  exec_sequencer #(.RESET_PC(8'hFF), .FETCH_TIMEOUT(15)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .pc(pc_b), .retire(retire_b),
    .halted(halted_b), .fault(fault_b), .dbg_sel(dbg_sel_b), .dbg_data(dbg_data_b)
  );

  // External ALU and instruction memory models
  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [1:0] imm,
                                       input logic sel);
    logic [7:0] x;
    x = sel ? {6'b0, imm} : b;
    case (op)
      2'b00:   return a + x;
      2'b01:   return a - x;
      2'b10:   return ~(a & x);
      default: return a + x;
    endcase
  endfunction

  assign bus_a.alu_result = alu_f(bus_a.alu_op, bus_a.alu_src1, bus_a.alu_src2,
                                  bus_a.alu_imm2, bus_a.alu_imm_sel);
  assign bus_a.alu_zero   = (bus_a.alu_result == 8'h00);
  assign bus_a.imem_valid = bus_a.imem_req & en_a;
  assign bus_a.imem_data  = prog_a[bus_a.imem_addr];

  assign bus_b.alu_result = alu_f(bus_b.alu_op, bus_b.alu_src1, bus_b.alu_src2,
                                  bus_b.alu_imm2, bus_b.alu_imm_sel);
  assign bus_b.alu_zero   = (bus_b.alu_result == 8'h00);
  assign bus_b.imem_valid = bus_b.imem_req & en_b;
  assign bus_b.imem_data  = prog_b[bus_b.imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard for DUT A retirements ----------------
  typedef struct packed {
    logic [7:0] ipc;
    logic [1:0] rd;
    logic [7:0] val;
    logic [7:0] npc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   pending = 1'b0;

  task automatic push(input logic [7:0] ipc, input logic [1:0] rd,
                      input logic [7:0] val, input logic [7:0] npc);
    exp_t e;
    e.ipc = ipc; e.rd = rd; e.val = val; e.npc = npc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (pending) begin
      chk("wb_reg_value", {24'h0, dbg_data_a}, {24'h0, cur.val});
      chk("next_pc", {24'h0, pc_a}, {24'h0, cur.npc});
      pending = 1'b0;
    end
    if (!rst_a && retire_a) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_retire: got retire at pc 0x%0h, required none", pc_a);
      end else begin
        cur = exp_q.pop_front();
        chk("retire_pc", {24'h0, pc_a}, {24'h0, cur.ipc});
        dbg_sel_a = cur.rd;
        pending   = 1'b1;
      end
    end
  end

  task automatic drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pending) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
      exp_q.delete();
      pending = 1'b0;
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc", {24'h0, pc_a}, 32'h0);
    chk("rst_retire", {31'h0, retire_a}, 32'h0);
    chk("rst_halted", {31'h0, halted_a}, 32'h0);
    chk("rst_fault", {31'h0, fault_a}, 32'h0);
    rst_a = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    for (int i = 0; i < 256; i++) begin
      prog_a[i] = 8'hF0;
      prog_b[i] = 8'hF0;
    end

    // ---- ADDI r0,1 then HALT; first-instruction latency and HALT freeze ----
    prog_a[0] = 8'h41;
    prog_a[1] = 8'hF0;
    push(8'h00, 2'd0, 8'h01, 8'h01);
    push(8'h01, 2'd0, 8'h01, 8'h01);
    reset_a();
    chk("rst_dbg_r0", {24'h0, dbg_data_a}, 32'h0);
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (retire_a) begin
        seen = 1'b1;
        break;
      end
    end
    chk("first_retire_cycle", seen ? n : 0, 32'd4);
    drain(50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_imem_req", {31'h0, bus_a.imem_req}, 32'h0);
    end
    chk("halt_pc_frozen", {24'h0, pc_a}, 32'h01);
    chk("halt_halted", {31'h0, halted_a}, 32'h1);
    chk("halt_no_fault", {31'h0, fault_a}, 32'h0);

    // ---- ADDI r1,3; SUB r1,r1; BZ -2 (taken, back to 0) ----
    prog_a[0] = 8'h47;
    prog_a[1] = 8'h15;
    prog_a[2] = 8'h8E;
    push(8'h00, 2'd1, 8'h03, 8'h01);
    push(8'h01, 2'd1, 8'h00, 8'h02);
    push(8'h02, 2'd3, 8'h00, 8'h00);
    reset_a();
    chk("restart_req", {31'h0, bus_a.imem_req}, 32'h1);
    drain(100);

    // ---- NANDI/NAND/NANDI, BZ not taken, SUBI wrap, NOP, HALT ----
    prog_a[0] = 8'h60;
    prog_a[1] = 8'h20;
    prog_a[2] = 8'h60;
    prog_a[3] = 8'h84;
    prog_a[4] = 8'h5B;
    prog_a[5] = 8'h3C;
    prog_a[6] = 8'hF0;
    push(8'h00, 2'd0, 8'hFF, 8'h01);
    push(8'h01, 2'd0, 8'h00, 8'h02);
    push(8'h02, 2'd0, 8'hFF, 8'h03);
    push(8'h03, 2'd1, 8'h00, 8'h04);
    push(8'h04, 2'd2, 8'hFD, 8'h05);
    push(8'h05, 2'd3, 8'h00, 8'h06);
    push(8'h06, 2'd0, 8'hFF, 8'h06);
    reset_a();
    drain(200);
    chk("seq3_halted", {31'h0, halted_a}, 32'h1);

    // ---- fetch timeout with imem_valid held low ----
    en_a = 1'b0;
    reset_a();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("timeout_fetch_req", {31'h0, bus_a.imem_req}, 32'h1);
      chk("timeout_not_halted", {31'h0, halted_a}, 32'h0);
    end
    @(negedge clk);
    chk("timeout_fault", {31'h0, fault_a}, 32'h1);
    chk("timeout_halted", {31'h0, halted_a}, 32'h1);
    chk("timeout_req_low", {31'h0, bus_a.imem_req}, 32'h0);
    en_a = 1'b1;
    repeat (5) @(negedge clk);
    chk("timeout_req_stays_low", {31'h0, bus_a.imem_req}, 32'h0);
    chk("timeout_pc", {24'h0, pc_a}, 32'h0);
    reset_a();
    chk("fault_cleared_req", {31'h0, bus_a.imem_req}, 32'h1);
    rst_a = 1'b1;

    // ---- DUT B: PC wrap from 0xFF, 3 stall cycles on fetch ----
    prog_b[8'hFF] = 8'h30;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_rst_pc", {24'h0, pc_b}, 32'hFF);
    en_b  = 1'b0;
    rst_b = 1'b0;
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (n == 4) en_b = 1'b1;
      if (retire_b) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b_stall_latency", seen ? n : 0, 32'd7);
    chk("b_retire_pc", {24'h0, pc_b}, 32'hFF);
    @(negedge clk);
    chk("b_pc_wrap", {24'h0, pc_b}, 32'h00);
    chk("b_retire_pulse", {31'h0, retire_b}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
